iq_phase_detector: RTL and testbench
====================================

// Module: iq_phase_detector
// PURPOSE
//  Recovers phase and magnitude from one I/Q sample pair using an iterative, vectoring-mode CORDIC.
//  It is the receive-side inverse of the team's quarter-wave sine NCO.
//  Its phase convention matches the NCO: i_val_i = A*sin(th) and i_val_q = -A*cos(th), with th = 2*pi*o_phase/2^PW.
//  It sits after the demod mixer/decimator and feeds the phase/frequency tracking loop.
// PARAMETERS
//  IW   16  input sample width, signed two's complement
//  PW   12  output phase width, unsigned; one full turn = 2^PW
//  ITER 14  number of CORDIC micro-rotations, range PW..IW+2
// PORTS
//  i_clk      in   1       clock; all state updates on the rising edge
//  i_reset_n  in   1       asynchronous, active-low reset
//  i_valid    in   1       input sample valid
//  o_ready    out  1       block can accept a sample (high only in IDLE)
//  i_val_i    in   IW      in-phase sample, signed
//  i_val_q    in   IW      quadrature sample, signed
//  o_valid    out  1       result valid; held until accepted
//  i_ready    in   1       downstream accepts the result
//  o_phase    out  PW      recovered phase, unsigned, wraps modulo 2^PW
//  o_mag      out  IW+1    magnitude*K, unsigned; K ~= 1.6468, not compensated
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - State returns to IDLE; o_ready=1, o_valid=0, o_phase=0, o_mag=0.
//   - Any in-flight sample is discarded with no output.
//  FSM states: IDLE -> PRE -> ITER -> DONE -> IDLE.
//   - IDLE:
//     - o_ready=1.
//     - Sample accepted when i_valid&&o_ready.
//     - Registers x=-Q and y=I, sign-extended to IW+2 bits; go to PRE.
//   - PRE (1 cycle): half-plane fold.
//     - If x<0: x=-x, y=-y, z=2^(PW+1) (180 deg in the PW+2-bit accumulator).
//     - Otherwise z=0.
//     - Clear iteration counter k=0; go to ITER.
//   - ITER (exactly ITER cycles), per cycle k:
//     - d=(y<0).
//     - x+=d ? -(y>>>k) : (y>>>k).
//     - y-=d ? -(x>>>k) : (x>>>k), using the pre-update x.
//     - z+=d ? -atan(2^-k) : atan(2^-k).
//     - After k=ITER-1, go to DONE.
//   - DONE:
//     - o_valid=1.
//     - o_phase = z[PW+1:2] + z[1], i.e. round-half-up then truncate; the wrap 2^PW -> 0 is required.
//     - o_mag = x[IW:0]; x is never negative after PRE.
//     - Outputs are stable while o_valid&&!i_ready.
//     - On i_ready: go to IDLE; o_valid drops next cycle.
//  Arithmetic and widths:
//   - x/y are IW+2 bits signed; no overflow is possible, including for -2^(IW-1) inputs.
//   - z is PW+2 bits unsigned, modulo arithmetic.
//   - The atan table is PW+2-bit constants, round(atan(2^-k)*2^(PW+2)/(2*pi)), built with a constant function.
//   - No file-based ROM.
//  Timing:
//   - Latency from accept edge to o_valid=1 is ITER+2 cycles.
//   - Throughput is one sample per ITER+3 cycles minimum.
//  Boundary conditions:
//   - I=Q=0 -> o_phase=0, o_mag=0.
//   - Full-scale negative inputs must not wrap.
//   - x<0,y=0 (th=180 deg) must resolve to exactly 2^(PW-1).
//   - i_valid while !o_ready is ignored; the source holds data.
//   - An i_ready-only pulse outside DONE has no effect.
//  Accuracy: |o_phase - ideal| <= 2 LSB for |A| >= 2^(IW-4).
// TESTING (IW=16, PW=12, ITER=14)
//  - I=0, Q=-32767 -> o_phase=0x000, o_mag ~= 53960 (+-4); o_valid exactly 16 cycles after accept.
//  - I=+32767,Q=0 -> 0x400; I=0,Q=+32767 -> 0x800; I=-32768,Q=0 -> 0xC00, no overflow.
//  - Loopback from the NCO: all 4096 phases -> o_phase within +-2 LSB of the driven phase, including the 0xFFF->0x000 wrap.
//  - Hold i_ready=0 for 10 cycles in DONE -> o_valid/o_phase/o_mag stable, o_ready=0, and the new i_valid is ignored.
//  - Assert i_reset_n=0 mid-ITER -> o_valid=0/o_ready=1 immediately (async); no stale result after release.
//  - I=Q=0 -> o_phase=0, o_mag=0; back-to-back samples with i_ready=1 -> one result per 17 cycles.

Source files
------------

// File: rtl/iq_phase_detector_if.sv
// Sample-in / result-out handshake bundle for the I/Q phase detector.
// The slave side is the detector; the master side feeds samples and takes results.
interface iq_phase_detector_if #(
    parameter int IW = 16,
    parameter int PW = 12
);
    logic                 i_valid;
    logic                 o_ready;
    logic signed [IW-1:0] i_val_i;
    logic signed [IW-1:0] i_val_q;
    logic                 o_valid;
    logic                 i_ready;
    logic [PW-1:0]        o_phase;
    logic [IW:0]          o_mag;

    modport slave (
        input  i_valid, i_val_i, i_val_q, i_ready,
        output o_ready, o_valid, o_phase, o_mag
    );

    modport master (
        output i_valid, i_val_i, i_val_q, i_ready,
        input  o_ready, o_valid, o_phase, o_mag
    );
endinterface

// File: rtl/iq_phase_detector.sv
// Vectoring-mode iterative CORDIC: one I/Q pair in, phase and scaled magnitude out.
// Phase convention: I = A*sin(th), Q = -A*cos(th), th = 2*pi*o_phase/2^PW.
module iq_phase_detector #(
    parameter int IW   = 16,
    parameter int PW   = 12,
    parameter int ITER = 14
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    iq_phase_detector_if.slave bus
);
    localparam int XW = IW + 2;
    localparam int ZW = PW + 2;
    localparam int KW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [ZW-1:0] Z_HALF = {2'b10, {PW{1'b0}}};

    // atan(2^-k) in ZW-bit turn units, from an integer Taylor series
    function automatic logic [ZW-1:0] atan_turn(input int k);
        logic [127:0] one;
        logic [127:0] pi_q;
        logic [127:0] term;
        logic [127:0] acc_p;
        logic [127:0] acc_n;
        logic [127:0] num;
        logic [127:0] res;
        logic [ZW-1:0] eighth;
        eighth = '0;
        eighth[ZW-3] = 1'b1;
        if (k == 0) begin
            return eighth;
        end
        one   = 128'd1 << 48;
        pi_q  = 128'h3243F6A8885A3;
        acc_p = '0;
        acc_n = '0;
        for (int n = 0; n < 26; n++) begin
            term = (one >> (k * (2 * n + 1))) / 128'(2 * n + 1);
            if (n % 2 == 0) begin
                acc_p = acc_p + term;
            end else begin
                acc_n = acc_n + term;
            end
        end
        num = (acc_p - acc_n) << (ZW - 1);
        res = (num + (pi_q >> 1)) / pi_q;
        return ZW'(res);
    endfunction

    function automatic logic [ITER*ZW-1:0] atan_table();
        logic [ITER*ZW-1:0] t;
        t = '0;
        for (int k = 0; k < ITER; k++) begin
            t[k*ZW +: ZW] = atan_turn(k);
        end
        return t;
    endfunction

    localparam logic [ITER*ZW-1:0] ATAN_TAB = atan_table();

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_ITER,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic signed [XW-1:0] r_x;
    logic signed [XW-1:0] r_y;
    logic [ZW-1:0]        r_z;
    logic [KW-1:0]        r_k;
    logic                 r_zero;
    logic [PW-1:0]        r_phase;
    logic [IW:0]          r_mag;

    logic [ZW-1:0]        w_atan [ITER];
    logic signed [XW-1:0] w_i_ext;
    logic signed [XW-1:0] w_q_ext;
    logic signed [XW-1:0] w_x_sh;
    logic signed [XW-1:0] w_y_sh;
    logic signed [XW-1:0] w_x_nx;
    logic signed [XW-1:0] w_y_nx;
    logic [ZW-1:0]        w_z_nx;
    logic [PW-1:0]        w_phase;
    logic                 w_d;
    logic                 w_last;
    logic                 w_accept;

    for (genvar g = 0; g < ITER; g++) begin : g_atan
        assign w_atan[g] = ATAN_TAB[g*ZW +: ZW];
    end

    assign w_i_ext  = {{2{bus.i_val_i[IW-1]}}, bus.i_val_i};
    assign w_q_ext  = {{2{bus.i_val_q[IW-1]}}, bus.i_val_q};
    assign w_last   = (r_k == KW'(ITER - 1));
    assign w_accept = bus.i_valid && (r_state == S_IDLE);

    assign bus.o_ready = (r_state == S_IDLE);
    assign bus.o_valid = (r_state == S_DONE);
    assign bus.o_phase = r_phase;
    assign bus.o_mag   = r_mag;

    // One micro-rotation: steer y toward zero, accumulate the angle in z
    always_comb begin
        w_d     = r_y[XW-1];
        w_x_sh  = r_x >>> r_k;
        w_y_sh  = r_y >>> r_k;
        w_x_nx  = w_d ? (r_x - w_y_sh) : (r_x + w_y_sh);
        w_y_nx  = w_d ? (r_y + w_x_sh) : (r_y - w_x_sh);
        w_z_nx  = w_d ? (r_z - w_atan[r_k]) : (r_z + w_atan[r_k]);
        w_phase = PW'((w_z_nx + ZW'(2)) >> 2);
    end

    // Next-state: IDLE -> PRE -> ITER x N -> DONE -> IDLE
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: if (bus.i_valid) w_state_nx = S_PRE;
            S_PRE:  w_state_nx = S_ITER;
            S_ITER: if (w_last) w_state_nx = S_DONE;
            S_DONE: if (bus.i_ready) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State register; reset drops any sample in flight
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Datapath: load, half-plane fold, iterate, latch rounded result
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_k     <= '0;
            r_zero  <= 1'b0;
            r_phase <= '0;
            r_mag   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x    <= -w_q_ext;
                        r_y    <= w_i_ext;
                        r_zero <= (bus.i_val_i == '0) && (bus.i_val_q == '0);
                    end
                end
                S_PRE: begin
                    r_k <= '0;
                    if (r_x[XW-1]) begin
                        r_x <= -r_x;
                        r_y <= -r_y;
                        r_z <= Z_HALF;
                    end else begin
                        r_z <= '0;
                    end
                end
                S_ITER: begin
                    r_x <= w_x_nx;
                    r_y <= w_y_nx;
                    r_z <= w_z_nx;
                    r_k <= r_k + 1'b1;
                    if (w_last) begin
                        r_phase <= r_zero ? '0 : w_phase;
                        r_mag   <= (IW+1)'(w_x_nx);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iq_phase_detector.sv
// Bench for iq_phase_detector: vector table, corner sequences, NCO loopback.
// Expected results queue on accept and are compared when the result handshakes.
module tb_iq_phase_detector;
    localparam int IW   = 16;
    localparam int PW   = 12;
    localparam int ITER = 14;
    localparam real PI  = 3.141592653589793;

    typedef struct {
        int vi;
        int vq;
        int ph;
        int ptol;
        int mag;
        int mtol;
    } vec_t;

    typedef struct {
        int ph;
        int ptol;
        int mag;
        int mtol;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    iq_phase_detector_if #(.IW(IW), .PW(PW)) bus ();

    iq_phase_detector #(.IW(IW), .PW(PW), .ITER(ITER)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    exp_t sb[$];
    int   out_cyc[$];
    int   errs = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_out = 0;
    vec_t vecs[9];

    task automatic chk(input bit ok, input string name,
                       input int act, input int req);
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic exp_t to_exp(input vec_t v);
        exp_t e;
        e.ph   = v.ph;
        e.ptol = v.ptol;
        e.mag  = v.mag;
        e.mtol = v.mtol;
        return e;
    endfunction

    always @(posedge clk) cyc++;

    exp_t m_e;
    int   m_d;
    int   m_m;

    always @(negedge clk) begin
        #1;
        if (rst_n && bus.o_valid && bus.i_ready) begin
            n_out++;
            out_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk(1'b0, "unexpected_result", int'(bus.o_phase), -1);
            end else begin
                m_e = sb.pop_front();
                m_d = (int'(bus.o_phase) - m_e.ph) & 4095;
                if (m_d >= 2048) m_d = m_d - 4096;
                if (m_d < 0) m_d = -m_d;
                chk(m_d <= m_e.ptol, "phase", int'(bus.o_phase), m_e.ph);
                m_m = int'(bus.o_mag) - m_e.mag;
                if (m_m < 0) m_m = -m_m;
                chk(m_m <= m_e.mtol, "mag", int'(bus.o_mag), m_e.mag);
            end
        end
    end

    task automatic send(input int vi, input int vq, input exp_t e,
                        input bit hold);
        int n;
        n = 0;
        bus.i_valid = 1'b1;
        bus.i_val_i = 16'(vi);
        bus.i_val_q = 16'(vq);
        while (!bus.o_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_ready) begin
            chk(1'b0, "accept_timeout", 0, 1);
            bus.i_valid = 1'b0;
        end else begin
            sb.push_back(e);
            @(negedge clk);
            if (!hold) bus.i_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk(1'b0, "drain_timeout", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   base;
        int   idx;
        int   n;
        int   vi;
        int   vq;
        real  th;
        exp_t e;

        bus.i_valid = 1'b0;
        bus.i_val_i = '0;
        bus.i_val_q = '0;
        bus.i_ready = 1'b1;

        vecs[0] = '{0, -32767, 0, 0, 53960, 4};
        vecs[1] = '{32767, 0, 1024, 0, 53960, 4};
        vecs[2] = '{0, 32767, 2048, 0, 53960, 4};
        vecs[3] = '{-32768, 0, 3072, 0, 53961, 4};
        vecs[4] = '{0, 0, 0, 0, 0, 0};
        vecs[5] = '{-32768, -32768, 3584, 2, 76312, 12};
        vecs[6] = '{3000, 3000, 1536, 2, 6987, 8};
        vecs[7] = '{20000, -10000, 722, 2, 36823, 12};
        vecs[8] = '{-5000, 12000, 2305, 2, 21408, 12};

        repeat (3) @(negedge clk);
        chk(bus.o_ready == 1'b1, "rst_o_ready", int'(bus.o_ready), 1);
        chk(bus.o_valid == 1'b0, "rst_o_valid", int'(bus.o_valid), 0);
        chk(bus.o_phase == '0, "rst_o_phase", int'(bus.o_phase), 0);
        chk(bus.o_mag == '0, "rst_o_mag", int'(bus.o_mag), 0);
        rst_n = 1'b1;
        @(negedge clk);

        send(vecs[0].vi, vecs[0].vq, to_exp(vecs[0]), 1'b0);
        lat = 1;
        while (!bus.o_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk(lat == 16, "latency", lat, 16);
        wait_drain();

        for (int i = 0; i < 9; i++) begin
            send(vecs[i].vi, vecs[i].vq, to_exp(vecs[i]), 1'b0);
            wait_drain();
        end

        bus.i_ready = 1'b0;
        base = n_out;
        send(vecs[1].vi, vecs[1].vq, to_exp(vecs[1]), 1'b0);
        repeat (3) @(negedge clk);
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        n = 0;
        while (!bus.o_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(bus.o_valid == 1'b1, "done_reached", int'(bus.o_valid), 1);
        bus.i_valid = 1'b1;
        bus.i_val_i = 16'(1234);
        bus.i_val_q = 16'(-5678);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk(bus.o_valid == 1'b1, "hold_o_valid", int'(bus.o_valid), 1);
            chk(bus.o_ready == 1'b0, "hold_o_ready", int'(bus.o_ready), 0);
            chk(bus.o_phase == 12'h400, "hold_o_phase",
                int'(bus.o_phase), 1024);
            chk(int'(bus.o_mag) >= 53956 && int'(bus.o_mag) <= 53964,
                "hold_o_mag", int'(bus.o_mag), 53960);
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        repeat (40) @(negedge clk);
        chk(n_out == base + 1, "hold_one_result", n_out - base, 1);
        chk(sb.size() == 0, "hold_sb_empty", sb.size(), 0);

        base = n_out;
        send(vecs[7].vi, vecs[7].vq, to_exp(vecs[7]), 1'b0);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk(bus.o_valid == 1'b0, "arst_o_valid", int'(bus.o_valid), 0);
        chk(bus.o_ready == 1'b1, "arst_o_ready", int'(bus.o_ready), 1);
        chk(bus.o_phase == '0, "arst_o_phase", int'(bus.o_phase), 0);
        chk(bus.o_mag == '0, "arst_o_mag", int'(bus.o_mag), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk(n_out == base, "arst_no_stale", n_out - base, 0);

        idx = out_cyc.size();
        send(vecs[1].vi, vecs[1].vq, to_exp(vecs[1]), 1'b1);
        send(vecs[2].vi, vecs[2].vq, to_exp(vecs[2]), 1'b1);
        send(vecs[3].vi, vecs[3].vq, to_exp(vecs[3]), 1'b0);
        wait_drain();
        if (out_cyc.size() >= idx + 3) begin
            chk(out_cyc[idx+1] - out_cyc[idx] == 17, "b2b_gap0",
                out_cyc[idx+1] - out_cyc[idx], 17);
            chk(out_cyc[idx+2] - out_cyc[idx+1] == 17, "b2b_gap1",
                out_cyc[idx+2] - out_cyc[idx+1], 17);
        end else begin
            chk(1'b0, "b2b_count", out_cyc.size() - idx, 3);
        end

        for (int p = 0; p < 4096; p++) begin
            th = 2.0 * PI * real'(p) / 4096.0;
            vi = int'($floor(32767.0 * $sin(th) + 0.5));
            vq = -int'($floor(32767.0 * $cos(th) + 0.5));
            e.ph   = p;
            e.ptol = 2;
            e.mag  = 53960;
            e.mtol = 40;
            send(vi, vq, e, 1'b1);
        end
        bus.i_valid = 1'b0;
        wait_drain();

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
